// File: rtl/sprite_ctrl_pkg.sv
// Shared types and operand layout for the per-frame sprite motion scheduler.
package sprite_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      APPLY  = 3'd1,
      MOVE   = 3'd2,
      ANIM   = 3'd3,
      COMMIT = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      OP_SET_POS = 2'd0,
      OP_SET_VEL = 2'd1,
      OP_SET_RUN = 2'd2,
      OP_SET_POP = 2'd3
   } cmd_op_e;

   localparam int CMD_W     = 21;
   localparam int POS_X_LSB = 0;
   localparam int POS_X_W   = 11;
   localparam int POS_Y_LSB = 11;
   localparam int POS_Y_W   = 10;
   localparam int FLAG_BIT  = 0;

   // Signed width used for the position+velocity sum; covers both axes.
   localparam int STEP_W    = 13;

endpackage

// File: rtl/axis_bounce.sv
// One-axis position step with clamp to [0, LIMIT] and velocity reflection; purely combinational.
module axis_bounce
   import sprite_ctrl_pkg::*;
#(
   parameter int CW    = 11,
   parameter int LIMIT = 1024,
   parameter int VEL_W = 5
) (
   input  logic              [CW-1:0]    pos_i,
   input  logic signed       [VEL_W-1:0] vel_i,
   output logic              [CW-1:0]    pos_o,
   output logic signed       [VEL_W-1:0] vel_o
);

   localparam logic signed [STEP_W-1:0] LIM_S   = STEP_W'(LIMIT);
   localparam logic signed [VEL_W-1:0]  VEL_MIN = VEL_W'(-(2 ** (VEL_W - 1)));
   localparam logic signed [VEL_W-1:0]  VEL_MAX = VEL_W'((2 ** (VEL_W - 1)) - 1);

   logic signed [STEP_W-1:0] nx;
   logic signed [VEL_W-1:0]  vel_neg;

   always_comb begin
      nx      = $signed({{(STEP_W - CW){1'b0}}, pos_i})
              + $signed({{(STEP_W - VEL_W){vel_i[VEL_W-1]}}, vel_i});
      // The most-negative velocity has no positive twin; saturate instead of wrapping.
      vel_neg = (vel_i == VEL_MIN) ? VEL_MAX : -vel_i;
      pos_o   = nx[CW-1:0];
      vel_o   = vel_i;
      if (nx[STEP_W-1]) begin
         pos_o = '0;
         vel_o = vel_neg;
      end else if (nx > LIM_S) begin
         pos_o = CW'(LIMIT);
         vel_o = vel_neg;
      end
   end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite scheduler: commands land in shadow state, then APPLY/MOVE/ANIM/COMMIT run once per
// frame from frame_start (outputs load 4 cycles later); commands stall (ready=0) outside IDLE.
module sprite_motion_ctrl
   import sprite_ctrl_pkg::*;
#(
   parameter int WIDTH       = 256,
   parameter int HEIGHT      = 256,
   parameter int H_ACTIVE    = 1280,
   parameter int V_ACTIVE    = 720,
   parameter int ANIM_FRAMES = 15,
   parameter int VEL_W       = 5
) (
   input  logic              pixel_clk_in,
   input  logic              rst_n_in,
   input  logic [10:0]       hcount_in,
   input  logic [9:0]        vcount_in,
   input  logic              cmd_valid_in,
   output logic              cmd_ready_out,
   input  logic [1:0]        cmd_op_in,
   input  logic [CMD_W-1:0]  cmd_data_in,
   output logic [10:0]       x_out,
   output logic [9:0]        y_out,
   output logic              pop_out,
   output logic              frame_tick_out
);

   localparam int X_MAX = H_ACTIVE - WIDTH;
   localparam int Y_MAX = V_ACTIVE - HEIGHT;
   localparam int AW    = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

   state_e                    state_q, state_d;
   logic [POS_X_W-1:0]        x_q, x_d, xo_q, xo_d, pend_x_q, pend_x_d, x_step;
   logic [POS_Y_W-1:0]        y_q, y_d, yo_q, yo_d, pend_y_q, pend_y_d, y_step;
   logic signed [VEL_W-1:0]   vx_q, vx_d, vy_q, vy_d, vx_step, vy_step;
   logic [AW-1:0]             anim_q, anim_d;
   logic                      pop_q, pop_d, popo_q, popo_d, pend_pop_q, pend_pop_d;
   logic                      pos_pend_q, pos_pend_d, pop_pend_q, pop_pend_d;
   logic                      pos_applied_q, pos_applied_d, run_q, run_d, tick_q, tick_d;
   logic                      frame_start;

   assign frame_start = (hcount_in == 11'(H_ACTIVE)) && (vcount_in == 10'(V_ACTIVE));

   axis_bounce #(.CW(POS_X_W), .LIMIT(X_MAX), .VEL_W(VEL_W)) u_axis_x (
      .pos_i(x_q), .vel_i(vx_q), .pos_o(x_step), .vel_o(vx_step)
   );

   axis_bounce #(.CW(POS_Y_W), .LIMIT(Y_MAX), .VEL_W(VEL_W)) u_axis_y (
      .pos_i(y_q), .vel_i(vy_q), .pos_o(y_step), .vel_o(vy_step)
   );

   always_comb begin
      state_d       = state_q;
      x_d           = x_q;
      y_d           = y_q;
      pop_d         = pop_q;
      vx_d          = vx_q;
      vy_d          = vy_q;
      run_d         = run_q;
      anim_d        = anim_q;
      pend_x_d      = pend_x_q;
      pend_y_d      = pend_y_q;
      pend_pop_d    = pend_pop_q;
      pos_pend_d    = pos_pend_q;
      pop_pend_d    = pop_pend_q;
      pos_applied_d = pos_applied_q;
      xo_d          = xo_q;
      yo_d          = yo_q;
      popo_d        = popo_q;
      // The frame wins a tie with a command; ready also stays low while reset is held.
      cmd_ready_out = rst_n_in && (state_q == IDLE) && !frame_start;

      unique case (state_q)
         IDLE: begin
            if (cmd_valid_in && cmd_ready_out) begin
               unique case (cmd_op_e'(cmd_op_in))
                  OP_SET_POS: begin
                     pend_x_d   = cmd_data_in[POS_X_LSB +: POS_X_W];
                     pend_y_d   = cmd_data_in[POS_Y_LSB +: POS_Y_W];
                     pos_pend_d = 1'b1;
                  end
                  OP_SET_VEL: begin
                     vx_d = cmd_data_in[0 +: VEL_W];
                     vy_d = cmd_data_in[VEL_W +: VEL_W];
                  end
                  OP_SET_RUN: run_d = cmd_data_in[FLAG_BIT];
                  OP_SET_POP: begin
                     pend_pop_d = cmd_data_in[FLAG_BIT];
                     pop_pend_d = 1'b1;
                  end
                  default: ;
               endcase
            end
            if (frame_start) state_d = APPLY;
         end
         APPLY: begin
            pos_applied_d = pos_pend_q;
            if (pos_pend_q) begin
               x_d        = (pend_x_q > 11'(X_MAX)) ? 11'(X_MAX) : pend_x_q;
               y_d        = (pend_y_q > 10'(Y_MAX)) ? 10'(Y_MAX) : pend_y_q;
               pos_pend_d = 1'b0;
            end
            if (pop_pend_q) begin
               pop_d      = pend_pop_q;
               anim_d     = '0;
               pop_pend_d = 1'b0;
            end
            state_d = MOVE;
         end
         MOVE: begin
            if (run_q && !pos_applied_q) begin
               x_d  = x_step;
               vx_d = vx_step;
               y_d  = y_step;
               vy_d = vy_step;
            end
            state_d = ANIM;
         end
         ANIM: begin
            if (run_q) begin
               if (anim_q == AW'(ANIM_FRAMES - 1)) begin
                  pop_d  = ~pop_q;
                  anim_d = '0;
               end else begin
                  anim_d = anim_q + AW'(1);
               end
            end
            state_d = COMMIT;
         end
         COMMIT: begin
            xo_d    = x_q;
            yo_d    = y_q;
            popo_d  = pop_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      tick_d = (state_d == COMMIT);
   end

   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q       <= IDLE;
         x_q           <= 11'(X_MAX / 2);
         y_q           <= 10'(Y_MAX / 2);
         pop_q         <= 1'b1;
         xo_q          <= 11'(X_MAX / 2);
         yo_q          <= 10'(Y_MAX / 2);
         popo_q        <= 1'b1;
         vx_q          <= '0;
         vy_q          <= '0;
         run_q         <= 1'b1;
         anim_q        <= '0;
         pend_x_q      <= '0;
         pend_y_q      <= '0;
         pend_pop_q    <= 1'b0;
         pos_pend_q    <= 1'b0;
         pop_pend_q    <= 1'b0;
         pos_applied_q <= 1'b0;
         tick_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         x_q           <= x_d;
         y_q           <= y_d;
         pop_q         <= pop_d;
         xo_q          <= xo_d;
         yo_q          <= yo_d;
         popo_q        <= popo_d;
         vx_q          <= vx_d;
         vy_q          <= vy_d;
         run_q         <= run_d;
         anim_q        <= anim_d;
         pend_x_q      <= pend_x_d;
         pend_y_q      <= pend_y_d;
         pend_pop_q    <= pend_pop_d;
         pos_pend_q    <= pos_pend_d;
         pop_pend_q    <= pop_pend_d;
         pos_applied_q <= pos_applied_d;
         tick_q        <= tick_d;
      end
   end

   assign x_out          = xo_q;
   assign y_out          = yo_q;
   assign pop_out        = popo_q;
   assign frame_tick_out = tick_q;

endmodule
